lzc_mask_builder: RTL and testbench

//   Inverse of the leading-zero counter: collects a stream of (index, empty) beats, as produced by
//   an lzc-based find-first-set iterator, and rebuilds the WIDTH-bit vector they describe.
//   A beat with last_i=1 closes the frame. The finished mask is then offered on a valid/ready output.

---
 rtl/lzc_mask_builder_pkg.sv | 14 +
 rtl/lzc_mask_builder_idx_dec.sv | 25 ++
 rtl/lzc_mask_builder.sv | 113 +++++++++++
 tb/tb_lzc_mask_builder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lzc_mask_builder_pkg.sv
// Shared types and helpers for the lzc mask builder.
package lzc_mask_builder_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_e;

    // Index width matching the lzc cnt_o encoding; a 1-bit vector still needs one index bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lzc_mask_builder_idx_dec.sv
// Index-to-one-hot decoder: maps an lzc (index, empty) pair onto a WIDTH-bit vector.
module lzc_idx_dec #(
    parameter int WIDTH     = 8,
    parameter int MODE      = 0,
    parameter int CNT_WIDTH = 3
) (
    input  logic [CNT_WIDTH-1:0] idx_i,
    input  logic                 empty_i,
    output logic [WIDTH-1:0]     onehot_o,
    output logic                 oor_o
);

    // WIDTH always fits in CNT_WIDTH+1 bits, so the range compare is exact.
    localparam logic [CNT_WIDTH:0] WMAX = (CNT_WIDTH+1)'(WIDTH);

    // Each output bit matches the one index that maps onto it; MODE flips the bit order.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        localparam logic [CNT_WIDTH-1:0] K = CNT_WIDTH'((MODE != 0) ? (WIDTH - 1 - b) : b);
        assign onehot_o[b] = !empty_i && (idx_i == K);
    end

    // Out-of-range only reachable when WIDTH is not a power of two.
    assign oor_o = !empty_i && ({1'b0, idx_i} >= WMAX);

endmodule

// File: rtl/lzc_mask_builder.sv
// Rebuilds a WIDTH-bit vector from a stream of lzc (index, empty) beats and
// offers the finished mask, its popcount and sticky dup/oor flags on valid/ready.
module lzc_mask_builder
    import lzc_mask_builder_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int MODE      = 0,
    localparam int CNT_WIDTH = idx_width(WIDTH),
    localparam int PW        = $clog2(WIDTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [CNT_WIDTH-1:0] idx_i,
    input  logic                 empty_i,
    input  logic                 last_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WIDTH-1:0]     mask_o,
    output logic [PW-1:0]        popcnt_o,
    output logic                 dup_o,
    output logic                 oor_o
);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [PW-1:0]     pop_q, pop_d;
    logic              dup_q, dup_d;
    logic              oor_q, oor_d;

    logic [WIDTH-1:0]  hot;
    logic              dec_oor;
    logic              accept;
    logic              hit;

    lzc_idx_dec #(
        .WIDTH     (WIDTH),
        .MODE      (MODE),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_dec (
        .idx_i    (idx_i),
        .empty_i  (empty_i),
        .onehot_o (hot),
        .oor_o    (dec_oor)
    );

    assign accept = valid_i && ready_o;
    assign hit    = |(hot & acc_q);

    // Next state: flush wins, last beat closes the frame, handshake reopens collection.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = COLLECT;
        end else begin
            case (state_q)
                COLLECT: if (accept && last_i) state_d = OUTPUT;
                OUTPUT:  if (ready_i)          state_d = COLLECT;
                default: state_d = COLLECT;
            endcase
        end
    end

    // Accumulator, popcount and sticky flags: merge accepted beats, clear on flush or handoff.
    always_comb begin
        acc_d = acc_q;
        pop_d = pop_q;
        dup_d = dup_q;
        oor_d = oor_q;
        if (flush_i || (state_q == OUTPUT && ready_i)) begin
            acc_d = '0;
            pop_d = '0;
            dup_d = 1'b0;
            oor_d = 1'b0;
        end else if (accept) begin
            acc_d = acc_q | hot;
            if (hit)           dup_d = 1'b1;
            else if (|hot)     pop_d = pop_q + PW'(1);
            if (dec_oor)       oor_d = 1'b1;
        end
    end

    // Handshake outputs decode directly from the state.
    always_comb begin
        ready_o = (state_q == COLLECT);
        valid_o = (state_q == OUTPUT);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= COLLECT;
            acc_q   <= '0;
            pop_q   <= '0;
            dup_q   <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            pop_q   <= pop_d;
            dup_q   <= dup_d;
            oor_q   <= oor_d;
        end
    end

    assign mask_o   = acc_q;
    assign popcnt_o = pop_q;
    assign dup_o    = dup_q;
    assign oor_o    = oor_q;

endmodule

// File: tb/tb_lzc_mask_builder.sv
// Bench for lzc_mask_builder: three configurations (W8/M0, W8/M1, W5/M0) share
// one stimulus stream; a per-configuration model pushes expected frames to queues.
module tb_lzc_mask_builder;

    logic       clk = 1'b0;
    logic       rst, flush_i, valid_i, empty_i, last_i, ready_i;
    logic [2:0] idx_i;

    logic       rdy0, rdy1, rdy2, v0, v1, v2, d0, d1, d2, o0, o1, o2;
    logic [7:0] mask0, mask1;
    logic [4:0] mask2;
    logic [3:0] pop0, pop1;
    logic [2:0] pop2;

    always #5 clk = ~clk;

    lzc_mask_builder #(.WIDTH(8), .MODE(0)) u_w8m0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy0),
        .idx_i(idx_i), .empty_i(empty_i), .last_i(last_i), .valid_o(v0), .ready_i(ready_i),
        .mask_o(mask0), .popcnt_o(pop0), .dup_o(d0), .oor_o(o0));

    lzc_mask_builder #(.WIDTH(8), .MODE(1)) u_w8m1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy1),
        .idx_i(idx_i), .empty_i(empty_i), .last_i(last_i), .valid_o(v1), .ready_i(ready_i),
        .mask_o(mask1), .popcnt_o(pop1), .dup_o(d1), .oor_o(o1));

    lzc_mask_builder #(.WIDTH(5), .MODE(0)) u_w5m0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy2),
        .idx_i(idx_i), .empty_i(empty_i), .last_i(last_i), .valid_o(v2), .ready_i(ready_i),
        .mask_o(mask2), .popcnt_o(pop2), .dup_o(d2), .oor_o(o2));

    typedef struct packed {
        logic [7:0] mask;
        logic [3:0] pop;
        logic       dup;
        logic       oor;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int   checks   = 0;
    int   failures = 0;

    int         m_w[3]    = '{8, 8, 5};
    int         m_mode[3] = '{0, 1, 0};
    logic [7:0] m_acc[3];
    int         m_pop[3];
    logic       m_dup[3], m_oor[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 3; c++) begin
            m_acc[c] = '0; m_pop[c] = 0; m_dup[c] = 1'b0; m_oor[c] = 1'b0;
        end
    endtask

    task automatic model_beat(input int idx, input logic empty, input logic last);
        exp_t e;
        int   b;
        for (int c = 0; c < 3; c++) begin
            if (!empty) begin
                if (idx < m_w[c]) begin
                    b = (m_mode[c] != 0) ? (m_w[c] - 1 - idx) : idx;
                    if (m_acc[c][b]) m_dup[c] = 1'b1;
                    else             m_pop[c]++;
                    m_acc[c][b] = 1'b1;
                end else begin
                    m_oor[c] = 1'b1;
                end
            end
            if (last) begin
                e = '{mask: m_acc[c], pop: 4'(m_pop[c]), dup: m_dup[c], oor: m_oor[c]};
                case (c)
                    0:       q0.push_back(e);
                    1:       q1.push_back(e);
                    default: q2.push_back(e);
                endcase
            end
        end
        if (last) model_clear();
    endtask

    // Drive one beat at the falling edge; the model sees it at the accepting rising edge.
    task automatic send(input int idx, input logic empty, input logic last);
        @(negedge clk);
        check("ready_o_collect", {rdy0, rdy1, rdy2}, 3'b111);
        valid_i = 1'b1; idx_i = 3'(idx); empty_i = empty; last_i = last;
        @(posedge clk);
        model_beat(idx, empty, last);
    endtask

    task automatic cmp_outputs(input exp_t e0, input exp_t e1, input exp_t e2);
        check("valid_o",    {v0, v1, v2}, 3'b111);
        check("ready_o_out",{rdy0, rdy1, rdy2}, 3'b000);
        check("mask_w8m0",  mask0, e0.mask); check("pop_w8m0", pop0, e0.pop);
        check("dup_w8m0",   d0, e0.dup);     check("oor_w8m0", o0, e0.oor);
        check("mask_w8m1",  mask1, e1.mask); check("pop_w8m1", pop1, e1.pop);
        check("dup_w8m1",   d1, e1.dup);     check("oor_w8m1", o1, e1.oor);
        check("mask_w5m0",  mask2, e2.mask); check("pop_w5m0", pop2, e2.pop);
        check("dup_w5m0",   d2, e2.dup);     check("oor_w5m0", o2, e2.oor);
    endtask

    // Wait (bounded) for the finished mask, compare it, optionally stall, then hand it off.
    task automatic expect_frame(input int hold);
        exp_t e0, e1, e2;
        int   n = 0;
        @(negedge clk);
        valid_i = 1'b0; last_i = 1'b0;
        while (!(v0 && v1 && v2) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 0);
        check("queue_nonempty", (q0.size() > 0 && q1.size() > 0 && q2.size() > 0), 1);
        if (q0.size() == 0 || q1.size() == 0 || q2.size() == 0) return;
        e0 = q0.pop_front(); e1 = q1.pop_front(); e2 = q2.pop_front();
        cmp_outputs(e0, e1, e2);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            cmp_outputs(e0, e1, e2);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check("valid_after_hs", {v0, v1, v2}, 3'b000);
        check("cleared_after_hs", {mask0, mask1, 3'b000, mask2, pop0, pop1, 1'b0, pop2}, 32'h0);
    endtask

    initial begin
        int nb;
        rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; empty_i = 1'b0;
        last_i = 1'b0; ready_i = 1'b0; idx_i = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_valid", {v0, v1, v2}, 3'b000);
        check("rst_ready", {rdy0, rdy1, rdy2}, 3'b111);
        check("rst_mask",  {mask0, mask1, mask2}, 32'h0);
        check("rst_misc",  {pop0, pop1, pop2, d0, d1, d2, o0, o1, o2}, 32'h0);
        rst = 1'b0;

        // basic frame, mode 0/1 mapping
        send(1, 0, 0); send(3, 0, 0); send(6, 0, 1);
        expect_frame(0);
        // same beats with a 5-cycle stall downstream
        send(1, 0, 0); send(3, 0, 0); send(6, 0, 1);
        expect_frame(5);
        // duplicate index and empty closing beat
        send(2, 0, 0); send(2, 0, 0); send(0, 1, 1);
        expect_frame(0);
        // out-of-range for WIDTH=5, then its top bit
        send(6, 0, 1); expect_frame(0);
        send(4, 0, 1); expect_frame(0);
        // flush beats a concurrent last beat
        send(0, 0, 0); send(7, 0, 0);
        @(negedge clk);
        flush_i = 1'b1; valid_i = 1'b1; idx_i = 3'd5; empty_i = 1'b0; last_i = 1'b1;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        flush_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("flush_no_valid", {v0, v1, v2}, 3'b000);
            check("flush_cleared", {mask0, mask1, 3'b000, mask2}, 32'h0);
            @(negedge clk);
        end
        send(3, 0, 1); expect_frame(0);
        // reset while the mask is pending
        send(1, 0, 1);
        @(negedge clk);
        valid_i = 1'b0; last_i = 1'b0;
        check("pre_rst_valid", {v0, v1, v2}, 3'b111);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", {v0, v1, v2}, 3'b000);
        check("midrst_ready", {rdy0, rdy1, rdy2}, 3'b111);
        check("midrst_mask",  {mask0, mask1, mask2}, 32'h0);
        rst = 1'b0;
        q0.delete(); q1.delete(); q2.delete();
        model_clear();
        // random back-to-back frames
        for (int f = 0; f < 25; f++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++)
                send($urandom_range(0, 7), ($urandom_range(0, 7) == 0), (b == nb - 1));
            expect_frame($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
